// File: rtl/dac_player_pkg.sv
// Shared definitions for the DAC pattern player: config addresses, CTRL bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dac_player_pkg;

  // Config bus register map
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_LENGTH = 2'd1;
  localparam logic [1:0] ADDR_PRESC  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // CTRL register bit positions; start/stop/ptr_clr are pulses, loop is stored
  localparam int CTRL_START  = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_STOP   = 2;
  localparam int CTRL_PTRCLR = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/dac_sample_mem.sv
// Sample buffer: DEPTH x DATA_W flop array, one write port, one combinational read port.
// Latency: write visible on the edge after we; read is combinational.
// Backpressure: none; a write is accepted every cycle we is high.
module dac_sample_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Cleared on reset so playback of an unloaded buffer is deterministic (all zeros)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dac_pattern_player.sv
// Replays a bytewise-loaded sample buffer to the DAC word at a programmable rate, one-shot or looped.
// Latency: first sample on o_digital one cycle after the CTRL start write; then every PRESC+1 cycles.
// Backpressure: none; DATA writes while playing are dropped, config writes always accepted.
module dac_pattern_player
  import dac_player_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [7:0]        cfg_wdata,
  output logic [DATA_W-1:0] o_digital,
  output logic              sample_strobe,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(NB - 1);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [BC_W-1:0]    byte_cnt_q;
  logic [DATA_W-1:0]  asm_q, asm_word;
  logic [PTR_W-1:0]   length_q;
  logic [PRESC_W-1:0] presc_q;
  logic               loop_q;

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               done_d;
  logic               load;
  logic [PTR_W-1:0]   load_idx;
  logic [DATA_W-1:0]  rd_data;

  logic data_wr, ctrl_wr, start_p, stop_p, ptrclr_p, mem_we;

  // Config decode; DATA and ptr_clr are only honoured while idle
  assign data_wr  = cfg_we && (cfg_addr == ADDR_DATA) && (state_q == ST_IDLE);
  assign ctrl_wr  = cfg_we && (cfg_addr == ADDR_CTRL);
  assign start_p  = ctrl_wr && cfg_wdata[CTRL_START];
  assign stop_p   = ctrl_wr && cfg_wdata[CTRL_STOP];
  assign ptrclr_p = ctrl_wr && cfg_wdata[CTRL_PTRCLR] && (state_q == ST_IDLE);
  assign mem_we   = data_wr && (byte_cnt_q == LAST_BYTE);

  // Little-endian byte insertion into the word being assembled
  always_comb begin
    asm_word = asm_q;
    asm_word[byte_cnt_q*8 +: 8] = cfg_wdata;
  end

  // Byte assembler, write pointer and config registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      length_q   <= '0;
      presc_q    <= '0;
      loop_q     <= 1'b0;
    end else begin
      if (data_wr) begin
        asm_q <= asm_word;
        if (byte_cnt_q == LAST_BYTE) begin
          byte_cnt_q <= '0;
          wr_ptr_q   <= wr_ptr_q + 1'b1;
        end else begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end
      if (ptrclr_p) begin
        wr_ptr_q   <= '0;
        byte_cnt_q <= '0;
      end
      if (cfg_we && (cfg_addr == ADDR_LENGTH)) begin
        length_q <= PTR_W'(cfg_wdata);
      end
      if (cfg_we && (cfg_addr == ADDR_PRESC)) begin
        presc_q <= PRESC_W'(cfg_wdata);
      end
      if (ctrl_wr) begin
        loop_q <= cfg_wdata[CTRL_LOOP];
      end
    end
  end

  dac_sample_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (asm_word),
    .raddr (load_idx),
    .rdata (rd_data)
  );

  // Playback FSM: decides when a new sample is loaded and from which index
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    done_d   = done_q_w();
    load     = 1'b0;
    load_idx = rd_ptr_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (start_p && !stop_p) begin
          state_d  = ST_PLAY;
          rd_ptr_d = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
          load     = 1'b1;
          load_idx = '0;
        end
      end
      ST_PLAY: begin
        if (stop_p) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          rd_ptr_d = '0;
          cnt_d    = '0;
          load     = 1'b1;
          load_idx = '0;
        end else if (cnt_q >= presc_q) begin
          // >= so a PRESC lowered mid-hold ends the hold instead of counting round
          cnt_d = '0;
          if (rd_ptr_q == length_q) begin
            if (loop_q) begin
              rd_ptr_d = '0;
              load     = 1'b1;
              load_idx = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            load     = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  function automatic logic done_q_w();
    return done;
  endfunction

  // FSM state, read pointer, prescaler and registered DAC outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      done          <= 1'b0;
      sample_strobe <= 1'b0;
      o_digital     <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      done          <= done_d;
      sample_strobe <= load;
      if (load) begin
        o_digital <= rd_data;
      end
    end
  end

  assign busy = (state_q == ST_PLAY);

endmodule

// File: tb/tb_dac_pattern_player.sv
module tb_dac_pattern_player;
  import dac_player_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic [15:0] o_digital;
  logic        sample_strobe, busy, done;

  int checks = 0;
  int errors = 0;

  dac_pattern_player #(.DATA_W(16), .DEPTH(16), .PRESC_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .o_digital     (o_digital),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled by the next rising edge and
  // the task returns at the following falling edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    wr(ADDR_DATA, w[7:0]);
    wr(ADDR_DATA, w[15:8]);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [15:0] pat [3];
  int          quiet;

  initial begin
    pat[0] = 16'h1234; pat[1] = 16'hABCD; pat[2] = 16'h0F0F;

    // 1: reset values and quiet idle
    #12;
    chk("rst_o", o_digital, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobe", sample_strobe, 0);
    @(negedge clk); rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_digital != 0 || busy || done || sample_strobe) quiet++;
    end
    chk("idle_quiet", quiet, 0);

    // 2: one-shot, PRESC=0
    for (int i = 0; i < 3; i++) load_word(pat[i]);
    wr(ADDR_LENGTH, 8'd2);
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_CTRL, 8'h01);
    chk("os_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("os_val", o_digital, pat[i]);
      chk("os_stb", sample_strobe, 1);
      step();
    end
    chk("os_done", done, 1);
    chk("os_busy_end", busy, 0);
    chk("os_hold", o_digital, 16'h0F0F);
    chk("os_stb_end", sample_strobe, 0);
    step(); step();
    chk("os_hold2", o_digital, 16'h0F0F);

    // 3: looped, PRESC=3, then stop
    wr(ADDR_PRESC, 8'd3);
    wr(ADDR_CTRL, 8'h03);
    chk("lp_done_clr", done, 0);
    for (int k = 0; k < 14; k++) begin
      chk("lp_val", o_digital, pat[(k / 4) % 3]);
      chk("lp_stb", sample_strobe, (k % 4) == 0);
      step();
    end
    wr(ADDR_CTRL, 8'h04);
    chk("stop_busy", busy, 0);
    chk("stop_hold", o_digital, 16'h1234);
    chk("stop_done", done, 0);
    chk("stop_stb", sample_strobe, 0);

    // 4: odd byte + ptr_clr, then DATA writes while busy are dropped
    wr(ADDR_DATA, 8'h77);
    wr(ADDR_CTRL, 8'h08);
    wr(ADDR_DATA, 8'h55);
    wr(ADDR_DATA, 8'hAA);
    wr(ADDR_LENGTH, 8'd0);
    wr(ADDR_PRESC, 8'd20);
    wr(ADDR_CTRL, 8'h01);
    chk("odd_mem0", o_digital, 16'hAA55);
    wr(ADDR_DATA, 8'h11);
    wr(ADDR_DATA, 8'h22);
    wr(ADDR_DATA, 8'h33);
    chk("busy_dw", busy, 1);
    wr(ADDR_CTRL, 8'h04);
    load_word(16'hBEEF);
    wr(ADDR_LENGTH, 8'd1);
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_CTRL, 8'h01);
    chk("bz_mem0", o_digital, 16'hAA55);
    step();
    chk("bz_mem1", o_digital, 16'hBEEF);
    step();
    chk("bz_done", done, 1);

    // 5: start+stop together, then restart mid-play
    wr(ADDR_LENGTH, 8'd2);
    wr(ADDR_PRESC, 8'd1);
    wr(ADDR_CTRL, 8'h03);
    wr(ADDR_CTRL, 8'h05);
    chk("ss_busy", busy, 0);
    chk("ss_hold", o_digital, 16'hAA55);
    chk("ss_done", done, 0);
    wr(ADDR_CTRL, 8'h03);
    step(); step(); step(); step();
    chk("rs_pre", o_digital, 16'h0F0F);
    chk("rs_pre_stb", sample_strobe, 1);
    wr(ADDR_CTRL, 8'h03);
    chk("rs_val", o_digital, 16'hAA55);
    chk("rs_stb", sample_strobe, 1);
    step();
    chk("rs_hold_stb", sample_strobe, 0);
    step();
    chk("rs_next", o_digital, 16'hBEEF);
    wr(ADDR_CTRL, 8'h04);

    // 6: write-pointer wrap, then async reset mid-play
    wr(ADDR_CTRL, 8'h08);
    for (int i = 0; i < 17; i++) load_word(16'h1000 + 16'(i));
    wr(ADDR_LENGTH, 8'd1);
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_CTRL, 8'h01);
    chk("wrap_mem0", o_digital, 16'h1010);
    step();
    chk("wrap_mem1", o_digital, 16'h1001);
    wr(ADDR_LENGTH, 8'd15);
    wr(ADDR_PRESC, 8'd5);
    wr(ADDR_CTRL, 8'h01);
    step(); step();
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_o", o_digital, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_stb", sample_strobe, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    wr(ADDR_CTRL, 8'h01);
    chk("pr_mem0", o_digital, 0);
    chk("pr_stb", sample_strobe, 1);
    step();
    chk("pr_len0_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
